// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit holding HI/LO.
// MULT/MULTU use shift-add on {acc, multiplier}; DIV/DIVU use restoring
// shift-subtract on operand magnitudes, with sign correction in FIN.
// MTHI/MTLO writes land directly in HI/LO while the unit is idle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic [WIDTH-1:0]   acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0]   mq_q, mq_d;     // multiplier / dividend-then-quotient
  logic [WIDTH-1:0]   b_q, b_d;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Operand sign and magnitude at the start edge (op[0]=0 means signed).
  logic               in_sign_a_s, in_sign_b_s;
  logic [WIDTH-1:0]   in_mag_a_s, in_mag_b_s;
  assign in_sign_a_s = ~op[0] & src_a[WIDTH-1];
  assign in_sign_b_s = ~op[0] & src_b[WIDTH-1];
  assign in_mag_a_s  = in_sign_a_s ? (~src_a + {{(WIDTH-1){1'b0}}, 1'b1}) : src_a;
  assign in_mag_b_s  = in_sign_b_s ? (~src_b + {{(WIDTH-1){1'b0}}, 1'b1}) : src_b;

  // One shift-add step: add multiplicand when the multiplier LSB is set,
  // then shift the 2*WIDTH {acc, mq} pair right by one.
  logic [WIDTH:0]     mul_sum_s;
  assign mul_sum_s = mq_q[0] ? ({1'b0, acc_q} + {1'b0, b_q}) : {1'b0, acc_q};

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor if it fits (borrow bit clear).
  logic [WIDTH:0]     div_shift_s;
  logic [WIDTH:0]     div_diff_s;
  assign div_shift_s = {acc_q, mq_q[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, b_q};

  // Final results before write-back.
  logic [2*WIDTH-1:0] prod_s, prod_neg_s;
  logic               neg_res_s;
  assign prod_s     = {acc_q, mq_q};
  assign prod_neg_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
  assign neg_res_s  = sign_a_q ^ sign_b_q;

  // Next-state, datapath and HI/LO update logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    div0_d   = div0_q;
    a_orig_d = a_orig_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d     = op;
          sign_a_d = in_sign_a_s;
          sign_b_d = in_sign_b_s;
          div0_d   = (src_b == {WIDTH{1'b0}});
          a_orig_d = src_a;
          acc_d    = {WIDTH{1'b0}};
          mq_d     = in_mag_a_s;
          b_d      = in_mag_b_s;
          cnt_d    = {CW{1'b0}};
          state_d  = S_RUN;
        end else begin
          if (hi_we) begin
            hi_d = wdata;
          end else begin
            hi_d = hi_q;
          end
          if (lo_we) begin
            lo_d = wdata;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      S_RUN: begin
        if (op_q[1]) begin
          if (!div_diff_s[WIDTH]) begin
            acc_d = div_diff_s[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift_s[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum_s[WIDTH:1];
          mq_d  = {mul_sum_s[0], mq_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_FIN: begin
        if (!op_q[1]) begin
          if (neg_res_s) begin
            {hi_d, lo_d} = prod_neg_s;
          end else begin
            {hi_d, lo_d} = prod_s;
          end
        end else if (div0_q) begin
          lo_d = {WIDTH{1'b1}};
          hi_d = a_orig_q;
        end else begin
          lo_d = neg_res_s ? (~mq_q + {{(WIDTH-1){1'b0}}, 1'b1}) : mq_q;
          hi_d = sign_a_q ? (~acc_q + {{(WIDTH-1){1'b0}}, 1'b1}) : acc_q;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_FIN);
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 2'b00;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      div0_q   <= 1'b0;
      a_orig_q <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      mq_q     <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      div0_q   <= div0_d;
      a_orig_q <= a_orig_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random
// operations compared against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         hi_we, lo_we;
  logic [W-1:0] wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_div_unit #(.WIDTH(W), .ITER(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition.
  task automatic ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] eh, output logic [W-1:0] el);
    longint     sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
      end
      default: begin
        if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin el = a / b; eh = a % b; end
      end
    endcase
  endtask

  // Enter at #1 after an edge; start is sampled at the next edge (edge 0).
  // Checks busy/done each cycle, HI/LO held through RUN, result at cycle 34.
  // inj > 0: at that cycle pulse start with other operands plus hi_we.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inj);
    logic [W-1:0] eh, el, ph, pl;
    ref_model(o, a, b, eh, el);
    ph = hi; pl = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    for (int c = 1; c <= 34; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom);
      end
      if (c == inj) begin
        start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_DEAD;
        src_a = $urandom; src_b = $urandom;
      end else if (c == inj + 1) begin
        start = 1'b0; hi_we = 1'b0;
      end
      check({tag, "_busy"}, 64'(busy), 64'(c <= 33));
      check({tag, "_done"}, 64'(done), 64'(c == 34));
      if (c <= 33) begin
        check({tag, "_hold"}, {hi, lo}, {ph, pl});
      end else begin
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
      end
    end
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    bit           seen;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    #2;
    check("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mult_neg3x7", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 0);
    run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0);
    run_op("divu_by0", 2'b11, 32'd5, 32'd0, 0);
    run_op("div_by0", 2'b10, 32'hFFFF_FFF0, 32'd0, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("multu_inj", 2'b01, 32'd3, 32'd4, 5);

    // Done cycle: MTLO write lands at the next edge, HI untouched.
    lo_we = 1'b1; wdata = 32'h0000_1234;
    @(posedge clk); #1;
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'd0, 32'h0000_1234});
    check("mtlo_idle", {62'd0, busy, done}, 64'd0);
    // Simultaneous MTHI/MTLO.
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

    // Start together with MTHI: write is dropped, operation runs.
    hi_we = 1'b1; wdata = 32'h0000_BEEF;
    run_op("start_wins", 2'b01, 32'd2, 32'd3, 0);

    // Start in the done cycle is accepted.
    run_op("b2b", 2'b11, 32'd1000, 32'd33, 0);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (i == 1) rb = rb >> $urandom_range(8, 28);
      run_op($sformatf("rand%0d", i), rop, ra, rb, 0);
    end

    // Asynchronous reset in the middle of a DIVU.
    start = 1'b1; op = 2'b11; src_a = 32'd999; src_b = 32'd10;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_rst_busy", 64'(busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst", {30'd0, busy, done, hi, lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("no_done_after_rst", 64'(seen), 64'd0);
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
